// File: rtl/aurora_rx_block_filter.sv
// aurora_rx_block_filter
// Qualifies lane lock from sync-header validity, discards idle control blocks,
// and buffers the remaining 66-bit blocks in a first-word-fall-through FIFO.
//
// Ports:
//   clk_rx_i     block clock (aurora_rx_lane output clock)
//   rst_n_i      asynchronous active-low reset
//   rx_data_i    64-bit block payload from lane
//   rx_header_i  2-bit sync header from lane
//   rx_valid_i   block strobe from lane
//   clear_i      synchronous clear of health counters and sticky flag
//   data_o       FIFO head payload
//   header_o     FIFO head header
//   valid_o      FIFO head valid
//   ready_i      consumer accept; pop when valid_o & ready_i
//   locked_o     lane-lock state
//   overflow_o   sticky: a block was dropped because the FIFO was full
//   err_cnt_o    invalid-header count, saturating
//   drop_cnt_o   overflow drop count, saturating
//   blk_cnt_o    blocks written to the FIFO, wrapping
module aurora_rx_block_filter #(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter logic [7:0]  IDLE_BTF      = 8'h78,
    parameter int unsigned LOCK_GOOD_CNT = 64,
    parameter int unsigned LOSS_ERR_CNT  = 16,
    parameter int unsigned ERR_WINDOW    = 1024
) (
    input  logic        clk_rx_i,
    input  logic        rst_n_i,
    input  logic [63:0] rx_data_i,
    input  logic [1:0]  rx_header_i,
    input  logic        rx_valid_i,
    input  logic        clear_i,
    output logic [63:0] data_o,
    output logic [1:0]  header_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        locked_o,
    output logic        overflow_o,
    output logic [15:0] err_cnt_o,
    output logic [15:0] drop_cnt_o,
    output logic [31:0] blk_cnt_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = $clog2(LOCK_GOOD_CNT + 1);
    localparam int unsigned WW = $clog2(ERR_WINDOW);
    localparam int unsigned EW = $clog2(LOSS_ERR_CNT + 1);

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } entry_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_good_cnt;
    logic [GW-1:0]   w_good_cnt_nxt;
    logic [WW-1:0]   r_win_cnt;
    logic [WW-1:0]   w_win_cnt_nxt;
    logic [EW-1:0]   r_win_err;
    logic [EW-1:0]   w_win_err_nxt;

    entry_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [15:0]     r_err_cnt;
    logic [15:0]     r_drop_cnt;
    logic [31:0]     r_blk_cnt;
    logic            r_overflow;

    logic            w_hdr_valid;
    logic            w_err_inc;
    logic            w_is_idle;
    logic            w_push_req;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic            w_win_wrap;
    logic [EW-1:0]   w_win_base;

    // Header classification and write qualification
    assign w_hdr_valid = (rx_header_i == HDR_DATA) || (rx_header_i == HDR_CTRL);
    assign w_err_inc   = rx_valid_i && !w_hdr_valid;
    assign w_is_idle   = (rx_header_i == HDR_CTRL) && (rx_data_i[63:56] == IDLE_BTF);
    assign w_push_req  = rx_valid_i && (r_state == ST_LOCKED) && w_hdr_valid && !w_is_idle;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_pop  = valid_o && ready_i;
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && w_full && !w_pop;

    // On the last block of a window the error tally restarts, so an invalid
    // header on that block is the first error of the new window
    assign w_win_wrap = (r_win_cnt == WW'(ERR_WINDOW - 1));
    assign w_win_base = w_win_wrap ? '0 : r_win_err;

    // Lock FSM state and its counters
    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_UNLOCKED;
            r_good_cnt <= '0;
            r_win_cnt  <= '0;
            r_win_err  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
            r_win_cnt  <= w_win_cnt_nxt;
            r_win_err  <= w_win_err_nxt;
        end
    end

    // Lock FSM next state
    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_win_cnt_nxt  = r_win_cnt;
        w_win_err_nxt  = r_win_err;
        if (rx_valid_i) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (!w_hdr_valid) begin
                        w_good_cnt_nxt = '0;
                    end else if (r_good_cnt == GW'(LOCK_GOOD_CNT - 1)) begin
                        w_state_nxt    = ST_LOCKED;
                        w_good_cnt_nxt = '0;
                        w_win_cnt_nxt  = '0;
                        w_win_err_nxt  = '0;
                    end else begin
                        w_good_cnt_nxt = r_good_cnt + GW'(1);
                    end
                end
                ST_LOCKED: begin
                    w_win_cnt_nxt = w_win_wrap ? '0 : r_win_cnt + WW'(1);
                    w_win_err_nxt = w_win_base;
                    if (!w_hdr_valid) begin
                        if (w_win_base == EW'(LOSS_ERR_CNT - 1)) begin
                            w_state_nxt    = ST_UNLOCKED;
                            w_good_cnt_nxt = '0;
                        end else begin
                            w_win_err_nxt = w_win_base + EW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                end
            endcase
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{hdr: rx_header_i, data: rx_data_i};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Health counters and sticky overflow; clear takes priority over increments
    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
            r_blk_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
            r_blk_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
            if (w_push) begin
                r_blk_cnt <= r_blk_cnt + 32'd1;
            end
        end
    end

    assign data_o     = r_mem[r_rd_ptr].data;
    assign header_o   = r_mem[r_rd_ptr].hdr;
    assign valid_o    = (r_count != '0);
    assign locked_o   = (r_state == ST_LOCKED);
    assign overflow_o = r_overflow;
    assign err_cnt_o  = r_err_cnt;
    assign drop_cnt_o = r_drop_cnt;
    assign blk_cnt_o  = r_blk_cnt;

endmodule

// File: doc/aurora_rx_block_filter.md
Name: aurora_rx_block_filter

Overview:
- Sits directly downstream of aurora_rx_lane, in the clk_rx_i domain.
- Consumes the lane's 66-bit block stream (rx_data_o, rx_header_o, rx_valid_o).
- Qualifies lane lock from header validity, discards idle control blocks, and buffers the remaining blocks in a FWFT FIFO with a valid/ready output.
- Reports health counters for lane-drop regression and status registers.

Parameters:
- FIFO_DEPTH, 16, entry count; power of 2, >=4.
- IDLE_BTF, 8'h78, block-type field (data[63:56]) of control blocks to discard.
- LOCK_GOOD_CNT, 64, consecutive valid-header blocks required to declare lock.
- LOSS_ERR_CNT, 16, invalid headers within one window that force loss of lock.
- ERR_WINDOW, 1024, window length in received blocks (rx_valid_i cycles).

Ports:
- clk_rx_i  in  1  block clock (same clock as aurora_rx_lane output).
- rst_n_i  in  1  asynchronous active-low reset.
- rx_data_i  in  64  block payload from lane.
- rx_header_i  in  2  sync header from lane.
- rx_valid_i  in  1  block strobe from lane.
- clear_i  in  1  synchronous clear of counters and sticky flags.
- data_o  out  64  FIFO head payload.
- header_o  out  2  FIFO head header.
- valid_o  out  1  FIFO head valid.
- ready_i  in  1  consumer accept; pop when valid_o & ready_i.
- locked_o  out  1  lane-lock state.
- overflow_o  out  1  sticky; a block was dropped because the FIFO was full.
- err_cnt_o  out  16  invalid-header count, saturating.
- drop_cnt_o  out  16  blocks dropped on overflow, saturating.
- blk_cnt_o  out  32  blocks written to FIFO, wrapping.

Behaviour:
- Reset (async assert, sync release): FSM=UNLOCKED, FIFO empty, all outputs 0, all counters 0.
- Header classes:
  - 2'b01 = data.
  - 2'b10 = control.
  - 2'b00 and 2'b11 = invalid. Every invalid header increments err_cnt_o (saturates at 16'hFFFF) in either state.
- All FSM and counter updates occur only on cycles with rx_valid_i=1. Cycles with rx_valid_i=0 are ignored entirely.
- FSM UNLOCKED:
  - good_cnt increments on each valid header and clears to 0 on an invalid header.
  - When the block that makes good_cnt reach LOCK_GOOD_CNT is received, go to LOCKED on the next edge; locked_o rises that same edge. That block itself is not written.
  - Window counters clear on entry to LOCKED.
- FSM LOCKED:
  - win_cnt counts received blocks 0..ERR_WINDOW-1. At wrap, win_err clears.
  - win_err increments on each invalid header.
  - If win_err would reach LOSS_ERR_CNT, go to UNLOCKED and clear good_cnt.
  - An invalid header arriving on the window-wrap cycle counts toward the new window (value 1).
- Write qualification: LOCKED & rx_valid_i & valid header & !(header==2'b10 & data[63:56]==IDLE_BTF). Blocks received in UNLOCKED and invalid-header blocks are never written.
- Write when full:
  - If a pop occurs in the same cycle, the write succeeds.
  - Otherwise the block is dropped, drop_cnt_o increments (saturating), and overflow_o sets.
- FIFO:
  - Count width is log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - A write accepted at edge N makes valid_o high after edge N when the FIFO was empty (one-cycle latency).
  - data_o and header_o stay stable while valid_o & !ready_i.
  - Simultaneous push and pop on an empty FIFO is illegal by construction, since valid_o=0 means no pop.
- blk_cnt_o increments per successful write and wraps at 2^32.
- Loss of lock does not flush the FIFO; stored blocks drain normally.
- clear_i:
  - Zeroes err_cnt_o, drop_cnt_o, blk_cnt_o and overflow_o.
  - An increment in the same cycle as clear_i is lost (clear wins).
  - The FSM and FIFO are unaffected.
- Asserting rst_n_i mid-operation empties the FIFO immediately and drops valid_o and locked_o asynchronously.

Test Plan:
1. Lock entry: after reset, drive 63 data blocks -> locked_o=0. The 64th block -> locked_o=1 one edge later, FIFO still empty. Block 65 (data=64'h5) -> valid_o=1 next cycle, data_o=64'h5, header_o=2'b01.
2. Lock interruption: 40 good blocks, 1 header 2'b11, then 63 good -> locked_o=0, err_cnt_o=1. One more good block -> locked_o=1.
3. Idle filter: locked; send {2'b10, 8'h78 in data[63:56]}, then {2'b10, 8'h1E}, then data 64'hA -> FIFO receives only the 8'h1E control block and 64'hA. blk_cnt_o=2.
4. Overflow: ready_i=0, locked, 20 data blocks with FIFO_DEPTH=16 -> 16 stored, drop_cnt_o=4, overflow_o=1. Then ready_i=1 -> blocks 0..15 pop in order. clear_i -> overflow_o=0, drop_cnt_o=0.
5. Full with concurrent pop: FIFO full, ready_i=1, new block arrives -> accepted, drop_cnt_o unchanged, count stays 16.
6. Loss of lock: locked; 16 invalid headers within 1024 blocks -> locked_o=0 after the 16th, err_cnt_o=16, already-queued blocks still drain. 15 invalid headers spread across a window boundary (8 + 7) -> lock held.
